ceyloniac_ram_loader: RTL and testbench

//  Upstream master for the RAM controller's external port. Takes a byte stream (valid/ready) from a host link.

---
 rtl/ceyloniac_ram_loader_if.sv | 32 +++
 rtl/ceyloniac_ram_loader.sv | 66 ++++++
 tb/tb_ceyloniac_ram_loader.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ceyloniac_ram_loader_if.sv
// ceyloniac_ram_loader_if: load request, host byte stream and RAM external-port signals
interface ceyloniac_ram_loader_if #(
    parameter int RAM_DATA_WIDTH = 32,
    parameter int RAM_ADDR_WIDTH = 16
);
    logic                      load_start;
    logic [RAM_ADDR_WIDTH-1:0] load_base_addr;
    logic [RAM_ADDR_WIDTH-1:0] load_word_count;
    logic [7:0]                byte_in;
    logic                      byte_valid;
    logic                      byte_ready;
    logic                      ram_external_control_enable;
    logic                      external_ram_enable;
    logic                      external_ram_write_enable;
    logic                      external_ram_read_enable;
    logic [RAM_ADDR_WIDTH-1:0] external_ram_addr;
    logic [RAM_DATA_WIDTH-1:0] external_ram_write_data;
    logic                      load_busy;
    logic                      load_done;
    modport master (
        input  load_start, load_base_addr, load_word_count, byte_in, byte_valid,
        output byte_ready, ram_external_control_enable, external_ram_enable,
               external_ram_write_enable, external_ram_read_enable, external_ram_addr,
               external_ram_write_data, load_busy, load_done
    );
    modport slave (
        output load_start, load_base_addr, load_word_count, byte_in, byte_valid,
        input  byte_ready, ram_external_control_enable, external_ram_enable,
               external_ram_write_enable, external_ram_read_enable, external_ram_addr,
               external_ram_write_data, load_busy, load_done
    );
endinterface

// File: rtl/ceyloniac_ram_loader.sv
// ceyloniac_ram_loader: packs a host byte stream into little-endian words and writes them to consecutive RAM addresses
module ceyloniac_ram_loader #(
    parameter int RAM_DATA_WIDTH = 32,
    parameter int RAM_ADDR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ceyloniac_ram_loader_if.master bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
    state_t                    state, state_nx;
    logic [1:0]                byte_idx;
    logic [RAM_ADDR_WIDTH-1:0] remaining, addr, wr_addr;
    logic [RAM_DATA_WIDTH-1:0] data, wr_data;
    logic                      accept;
    assign accept = state == COLLECT && bus.byte_valid;
    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.load_start ? (bus.load_word_count == '0 ? DONE : COLLECT) : IDLE;
            COLLECT: state_nx = accept && byte_idx == 2'd3 ? WRITE : COLLECT;
            WRITE:   state_nx = remaining == 1 ? DONE : COLLECT;
            default: state_nx = IDLE;
        endcase
    end
    // wr_addr/wr_data latch on the 4th byte so they are valid during WRITE and hold afterwards
    always_ff @(posedge clk)
        if (!rst_n) begin
            byte_idx  <= '0;
            remaining <= '0;
            addr      <= '0;
            data      <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            if (state == IDLE && bus.load_start) begin
                remaining <= bus.load_word_count;
                addr      <= bus.load_base_addr;
                byte_idx  <= '0;
            end
            if (accept) begin
                data[{byte_idx, 3'b000} +: 8] <= bus.byte_in;
                byte_idx                      <= byte_idx + 1'b1;
            end
            if (accept && byte_idx == 2'd3) begin
                wr_addr <= addr;
                wr_data <= {bus.byte_in, data[23:0]};
            end
            if (state == WRITE) begin
                remaining <= remaining - 1'b1;
                addr      <= addr + 1'b1;
            end
        end
    assign bus.byte_ready                  = state == COLLECT;
    assign bus.ram_external_control_enable = state == COLLECT || state == WRITE;
    assign bus.load_busy                   = state == COLLECT || state == WRITE;
    assign bus.external_ram_enable         = state == WRITE;
    assign bus.external_ram_write_enable   = state == WRITE;
    assign bus.external_ram_read_enable    = 1'b0;
    assign bus.external_ram_addr           = wr_addr;
    assign bus.external_ram_write_data     = wr_data;
    assign bus.load_done                   = state == DONE;
endmodule

// File: tb/tb_ceyloniac_ram_loader.sv
// tb_ceyloniac_ram_loader: directed loads with a write scoreboard and a RAM model read back at the end
module tb_ceyloniac_ram_loader;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;
    ceyloniac_ram_loader_if #(.RAM_DATA_WIDTH(32), .RAM_ADDR_WIDTH(16)) bus ();
    ceyloniac_ram_loader #(.RAM_DATA_WIDTH(32), .RAM_ADDR_WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct packed {logic [15:0] a; logic [31:0] d;} wr_t;
    wr_t         exp_q[$];
    logic [31:0] mem[logic [15:0]];
    logic [31:0] exp_mem[logic [15:0]];
    int          vectors = 0;
    int          miscompares = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic expect_wr(input logic [15:0] a, input logic [31:0] d);
        exp_q.push_back(wr_t'({a, d}));
        exp_mem[a] = d;
    endtask
    // monitor: every write pulse on the external port must match the oldest expected write
    always @(negedge clk)
        if (bus.external_ram_enable) begin : mon
            wr_t e;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %h data %h expected none",
                         bus.external_ram_addr, bus.external_ram_write_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.external_ram_addr), 32'(e.a));
                chk("wr_data", bus.external_ram_write_data, e.d);
                chk("wr_we", 32'(bus.external_ram_write_enable), 1);
                chk("rd_en", 32'(bus.external_ram_read_enable), 0);
            end
            if (bus.external_ram_write_enable) mem[bus.external_ram_addr] = bus.external_ram_write_data;
        end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start(input logic [15:0] base, input logic [15:0] cnt);
        bus.load_base_addr  = base;
        bus.load_word_count = cnt;
        bus.load_start      = 1;
        tick();
        bus.load_start = 0;
    endtask
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        if (gap) begin
            bus.byte_valid = 0;
            tick();
        end
        bus.byte_in    = b;
        bus.byte_valid = 1;
        while (!bus.byte_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("byte_ready_timeout", 0, 1);
        tick();
        bus.byte_valid = 0;
    endtask
    task automatic check_write_cycle();
        chk("ready_in_write", 32'(bus.byte_ready), 0);
        chk("en_in_write", 32'(bus.external_ram_enable), 1);
        chk("ctrl_in_write", 32'(bus.ram_external_control_enable), 1);
    endtask
    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k+:8], gap);
        check_write_cycle();
    endtask
    task automatic check_done();
        tick();
        chk("done_pulse", 32'(bus.load_done), 1);
        chk("done_ctrl", 32'(bus.ram_external_control_enable), 0);
        chk("done_busy", 32'(bus.load_busy), 0);
        tick();
        chk("done_clear", 32'(bus.load_done), 0);
    endtask
    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, 32'(bus.ram_external_control_enable), 0);
        chk({tag, "_en"}, 32'(bus.external_ram_enable), 0);
        chk({tag, "_we"}, 32'(bus.external_ram_write_enable), 0);
        chk({tag, "_re"}, 32'(bus.external_ram_read_enable), 0);
        chk({tag, "_ready"}, 32'(bus.byte_ready), 0);
        chk({tag, "_busy"}, 32'(bus.load_busy), 0);
        chk({tag, "_done"}, 32'(bus.load_done), 0);
        chk({tag, "_addr"}, 32'(bus.external_ram_addr), 0);
        chk({tag, "_wdata"}, bus.external_ram_write_data, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
    initial begin
        bus.load_start = 0;
        bus.load_base_addr = 0;
        bus.load_word_count = 0;
        bus.byte_in = 0;
        bus.byte_valid = 0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1;
        tick();
        // 1: back-to-back bytes
        expect_wr(16'h0010, 32'h44332211);
        expect_wr(16'h0011, 32'h88776655);
        start(16'h0010, 16'd2);
        chk("t1_busy", 32'(bus.load_busy), 1);
        chk("t1_ctrl", 32'(bus.ram_external_control_enable), 1);
        send_word(32'h44332211, 0);
        send_word(32'h88776655, 0);
        check_done();
        // 2: byte_valid toggling
        expect_wr(16'h0050, 32'h44332211);
        expect_wr(16'h0051, 32'h88776655);
        start(16'h0050, 16'd2);
        send_word(32'h44332211, 1);
        send_word(32'h88776655, 1);
        check_done();
        // 3: zero count
        start(16'h0070, 16'd0);
        chk("t3_done", 32'(bus.load_done), 1);
        chk("t3_ctrl", 32'(bus.ram_external_control_enable), 0);
        tick();
        chk("t3_done_clear", 32'(bus.load_done), 0);
        // 4: address wrap
        expect_wr(16'hFFFF, 32'hA4A3A2A1);
        expect_wr(16'h0000, 32'hA8A7A6A5);
        start(16'hFFFF, 16'd2);
        send_word(32'hA4A3A2A1, 0);
        send_word(32'hA8A7A6A5, 0);
        check_done();
        // 5: reset mid-word, then a fresh load
        start(16'h0020, 16'd1);
        send_byte(8'h5A, 0);
        send_byte(8'hA5, 0);
        rst_n = 0;
        tick();
        check_all_zero("midrst");
        rst_n = 1;
        tick();
        expect_wr(16'h0030, 32'hEFBEADDE);
        start(16'h0030, 16'd1);
        send_word(32'hEFBEADDE, 0);
        check_done();
        // 6: load_start during a load is ignored
        expect_wr(16'h0040, 32'h04030201);
        expect_wr(16'h0041, 32'h0D0C0B0A);
        start(16'h0040, 16'd2);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        bus.load_base_addr  = 16'h0099;
        bus.load_word_count = 16'd5;
        bus.load_start      = 1;
        tick();
        bus.load_start = 0;
        chk("t6_still_busy", 32'(bus.load_busy), 1);
        send_byte(8'h04, 0);
        check_write_cycle();
        send_word(32'h0D0C0B0A, 0);
        check_done();
        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 0);
        chk("mem_entries", mem.num(), exp_mem.num());
        foreach (exp_mem[a]) chk($sformatf("readback_%h", a), mem.exists(a) ? mem[a] : 32'hx, exp_mem[a]);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
